updown_modulo_counter: RTL and testbench

//  Parametrised up/down counter with programmable terminal value, step size,

---
 rtl/updown_counter_pkg.sv | 9 +
 rtl/counter_next_calc.sv | 55 +++++
 rtl/updown_modulo_counter.sv | 58 +++++
 tb/tb_updown_modulo_counter.sv | 164 ++++++++++++++++
 4 files changed

// File: rtl/updown_counter_pkg.sv
// Shared direction/mode encodings for the up/down modulo counter.
package updown_counter_pkg;

   localparam logic DIR_DOWN  = 1'b0;
   localparam logic DIR_UP    = 1'b1;
   localparam logic MODE_WRAP = 1'b0;
   localparam logic MODE_SAT  = 1'b1;

endpackage

// File: rtl/counter_next_calc.sv
// Combinational next-count and boundary-event calculation for one enabled step.
module counter_next_calc
   import updown_counter_pkg::*;
#(
   parameter int unsigned WIDTH  = 8,
   parameter int unsigned STEP_W = 4
) (
   input  logic [WIDTH-1:0]  count,
   input  logic [STEP_W-1:0] step,
   input  logic [WIDTH-1:0]  max_val,
   input  logic              up_down,
   input  logic              sat_mode,
   output logic [WIDTH-1:0]  next_count,
   output logic              next_evt
);

   localparam int unsigned EXT_W = WIDTH + 1;

   logic [EXT_W-1:0] count_ext;
   logic [EXT_W-1:0] max_ext;
   logic [EXT_W-1:0] step_ext;
   logic [EXT_W-1:0] sum;
   logic [EXT_W-1:0] diff;

   // One extra bit keeps the carry/borrow so overflow can never alias into range.
   assign count_ext = EXT_W'(count);
   assign max_ext   = EXT_W'(max_val);
   assign step_ext  = EXT_W'(step);
   assign sum       = count_ext + step_ext;
   assign diff      = count_ext - step_ext;

   always_comb begin
      next_count = count;
      next_evt   = 1'b0;
      if (count > max_val) begin
         // max_val was lowered below the current count: snap back into range quietly.
         next_count = max_val;
      end else if (up_down == DIR_UP) begin
         if (sum > max_ext) begin
            next_evt   = 1'b1;
            next_count = (sat_mode == MODE_SAT) ? max_val : '0;
         end else begin
            next_count = sum[WIDTH-1:0];
         end
      end else begin
         if (diff[WIDTH]) begin
            next_evt   = 1'b1;
            next_count = (sat_mode == MODE_SAT) ? '0 : max_val;
         end else begin
            next_count = diff[WIDTH-1:0];
         end
      end
   end

endmodule

// File: rtl/updown_modulo_counter.sv
// Up/down counter with programmable terminal value, step, load and wrap/saturate mode.
module updown_modulo_counter
   import updown_counter_pkg::*;
#(
   parameter int unsigned WIDTH  = 8,
   parameter int unsigned STEP_W = 4
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              en,
   input  logic              up_down,
   input  logic              sat_mode,
   input  logic [STEP_W-1:0] step,
   input  logic [WIDTH-1:0]  max_val,
   input  logic              load,
   input  logic [WIDTH-1:0]  load_val,
   output logic [WIDTH-1:0]  count,
   output logic              evt,
   output logic              at_max,
   output logic              at_zero
);

   logic [WIDTH-1:0] next_count;
   logic             next_evt;

   counter_next_calc #(
      .WIDTH  (WIDTH),
      .STEP_W (STEP_W)
   ) u_next_calc (
      .count      (count),
      .step       (step),
      .max_val    (max_val),
      .up_down    (up_down),
      .sat_mode   (sat_mode),
      .next_count (next_count),
      .next_evt   (next_evt)
   );

   // Priority: reset > load > en > hold; evt only survives an enabled step.
   always_ff @(posedge clk) begin
      if (reset) begin
         count <= '0;
         evt   <= 1'b0;
      end else if (load) begin
         count <= (load_val > max_val) ? max_val : load_val;
         evt   <= 1'b0;
      end else if (en) begin
         count <= next_count;
         evt   <= next_evt;
      end else begin
         evt   <= 1'b0;
      end
   end

   assign at_max  = (count == max_val);
   assign at_zero = (count == '0);

endmodule

// File: tb/tb_updown_modulo_counter.sv
// Self-checking bench: directed scenarios plus random traffic against an arithmetic model.
module tb_updown_modulo_counter;

   logic       clk = 1'b0;
   logic       reset, en, up_down, sat_mode, load;
   logic [3:0] step;
   logic [7:0] max_val, load_val;
   logic [7:0] count;
   logic       evt, at_max, at_zero;

   int n_chk = 0;
   int n_bad = 0;
   int m_cnt = 0;
   int m_evt = 0;

   updown_modulo_counter #(.WIDTH(8), .STEP_W(4)) dut (
      .clk      (clk),
      .reset    (reset),
      .en       (en),
      .up_down  (up_down),
      .sat_mode (sat_mode),
      .step     (step),
      .max_val  (max_val),
      .load     (load),
      .load_val (load_val),
      .count    (count),
      .evt      (evt),
      .at_max   (at_max),
      .at_zero  (at_zero)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input int got, input int exp);
      n_chk++;
      if (got != exp) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   // Reference: plain integer arithmetic on the documented rules.
   task automatic model_step();
      int mv, st;
      mv = int'(max_val);
      st = int'(step);
      if (reset) begin
         m_cnt = 0; m_evt = 0;
      end else if (load) begin
         m_cnt = (int'(load_val) < mv) ? int'(load_val) : mv;
         m_evt = 0;
      end else if (!en) begin
         m_evt = 0;
      end else if (m_cnt > mv) begin
         m_cnt = mv; m_evt = 0;
      end else if (up_down) begin
         if (m_cnt + st > mv) begin
            m_evt = 1; m_cnt = sat_mode ? mv : 0;
         end else begin
            m_evt = 0; m_cnt = m_cnt + st;
         end
      end else begin
         if (m_cnt - st < 0) begin
            m_evt = 1; m_cnt = sat_mode ? 0 : mv;
         end else begin
            m_evt = 0; m_cnt = m_cnt - st;
         end
      end
   endtask

   task automatic cyc(input string tag, input logic r, input logic ld, input logic e,
                      input logic ud, input logic sm, input int st, input int mv, input int lv);
      reset = r; load = ld; en = e; up_down = ud; sat_mode = sm;
      step = 4'(st); max_val = 8'(mv); load_val = 8'(lv);
      model_step();
      @(posedge clk);
      #1;
      check({tag, "_cnt"}, int'(count), m_cnt);
      check({tag, "_evt"}, int'(evt), m_evt);
      check({tag, "_atmax"}, int'(at_max), int'(m_cnt == mv));
      check({tag, "_atzero"}, int'(at_zero), int'(m_cnt == 0));
   endtask

   initial begin
      int exp_seq [12];
      int mv_r, hold_r;

      reset = 1'b1; load = 1'b0; en = 1'b0; up_down = 1'b1; sat_mode = 1'b0;
      step = '0; max_val = 8'd9; load_val = '0;
      cyc("rst0", 1, 0, 0, 1, 0, 0, 9, 0);
      check("rst0_abs", int'(count), 0);

      // Reset mid-count, with a simultaneous load that must be ignored
      cyc("t1_ld", 0, 1, 0, 1, 0, 0, 9, 5);
      check("t1_ld5", int'(count), 5);
      cyc("t1_rst", 1, 1, 1, 1, 0, 1, 9, 7);
      check("t1_zero", int'(count), 0);

      // Wrap up by 1 through max_val=9
      exp_seq = '{1, 2, 3, 4, 5, 6, 7, 8, 9, 0, 1, 2};
      for (int i = 0; i < 12; i++) begin
         cyc("t2", 0, 0, 1, 1, 0, 1, 9, 0);
         check("t2_seq", int'(count), exp_seq[i]);
         check("t2_evt", int'(evt), int'(exp_seq[i] == 0));
      end

      // Down by 3 from 4: wrap then saturate
      cyc("t3_ld", 0, 1, 0, 0, 0, 3, 9, 4);
      cyc("t3w1", 0, 0, 1, 0, 0, 3, 9, 0); check("t3w1_abs", int'(count), 1);
      cyc("t3w2", 0, 0, 1, 0, 0, 3, 9, 0); check("t3w2_abs", int'(count), 9);
      check("t3w2_evt_abs", int'(evt), 1);
      cyc("t3w3", 0, 0, 1, 0, 0, 3, 9, 0); check("t3w3_abs", int'(count), 6);
      cyc("t3_ld2", 0, 1, 0, 0, 1, 3, 9, 4);
      cyc("t3s1", 0, 0, 1, 0, 1, 3, 9, 0); check("t3s1_abs", int'(count), 1);
      cyc("t3s2", 0, 0, 1, 0, 1, 3, 9, 0); check("t3s2_abs", int'(count), 0);
      cyc("t3s3", 0, 0, 1, 0, 1, 3, 9, 0); check("t3s3_evt_abs", int'(evt), 1);

      // Load clamps to max_val; load beats en
      cyc("t4_ld", 0, 1, 0, 1, 0, 1, 100, 200);
      check("t4_abs", int'(count), 100);
      check("t4_atmax_abs", int'(at_max), 1);
      cyc("t4_lden", 0, 1, 1, 1, 0, 5, 100, 30);
      check("t4_lden_abs", int'(count), 30);

      // max_val lowered below count, then wrap
      cyc("t5_ld", 0, 1, 0, 1, 0, 1, 100, 50);
      cyc("t5_clip", 0, 0, 1, 1, 0, 1, 20, 0);
      check("t5_clip_abs", int'(count), 20);
      check("t5_clip_evt_abs", int'(evt), 0);
      cyc("t5_wrap", 0, 0, 1, 1, 0, 1, 20, 0);
      check("t5_wrap_abs", int'(count), 0);

      // No 8-bit overflow at max_val=255
      cyc("t6_ld", 0, 1, 0, 1, 1, 15, 255, 250);
      cyc("t6_sat", 0, 0, 1, 1, 1, 15, 255, 0);
      check("t6_sat_abs", int'(count), 255);
      cyc("t6_ld2", 0, 1, 0, 1, 0, 15, 255, 250);
      cyc("t6_wrap", 0, 0, 1, 1, 0, 15, 255, 0);
      check("t6_wrap_abs", int'(count), 0);

      // max_val == 0 and step == 0 corners
      cyc("z_up", 0, 0, 1, 1, 0, 2, 0, 0);
      cyc("z_dn", 0, 0, 1, 0, 1, 1, 0, 0);
      cyc("s0_ld", 0, 1, 0, 1, 0, 0, 9, 6);
      cyc("s0", 0, 0, 1, 1, 1, 0, 9, 0);

      // Random traffic; max_val held for a few cycles at a time
      mv_r = 9; hold_r = 0;
      for (int i = 0; i < 3000; i++) begin
         if (hold_r == 0) begin
            mv_r = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 3) : $urandom_range(0, 255);
            hold_r = $urandom_range(1, 20);
         end
         hold_r--;
         cyc("rnd", 1'($urandom_range(0, 99) == 0), 1'($urandom_range(0, 19) == 0),
             1'($urandom_range(0, 9) < 8), 1'($urandom), 1'($urandom),
             $urandom_range(0, 15), mv_r, $urandom_range(0, 255));
      end

      $display("test done: total=%0d bad=%0d", n_chk, n_bad);
      $finish;
   end

endmodule
